// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for a shared-memory, shared-ALU datapath.
// Optional illegal-opcode trap (HALT state, IllegalOp port) enabled by CTRL_ILLEGAL_TRAP_EN.
module multicycle_control_unit #(
   parameter int unsigned             OP_W    = 6,
   parameter int unsigned             ALUC_W  = 4,
   parameter logic [OP_W-1:0]         OP_ADD  = 6'b000001,
   parameter logic [OP_W-1:0]         OP_LW   = 6'b000010,
   parameter logic [OP_W-1:0]         OP_SW   = 6'b000101,
   parameter logic [OP_W-1:0]         OP_BEQ  = 6'b000100,
   parameter logic [OP_W-1:0]         OP_ADDI = 6'b001000,
   parameter logic [ALUC_W-1:0]       ALU_ADD = 4'b0101,
   parameter logic [ALUC_W-1:0]       ALU_SUB = 4'b0110
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [OP_W-1:0]   Op,
   input  logic              Zero,
   input  logic              MemReady,
   output logic              PCWrite,
   output logic              IRWrite,
   output logic              IorD,
   output logic              MemRead,
   output logic              MemWrite,
   output logic              MemToReg,
   output logic              RegDst,
   output logic              RegWrite,
   output logic              ALUSrcA,
   output logic [1:0]        ALUSrcB,
   output logic [ALUC_W-1:0] ALUcontrol,
   output logic              PCSrc,
   output logic [2:0]        State
`ifdef CTRL_ILLEGAL_TRAP_EN
   ,
   output logic              IllegalOp
`endif
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
`ifdef CTRL_ILLEGAL_TRAP_EN
      ,
      S_HALT   = 3'd5
`endif
   } state_e;

   state_e            state_q, state_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic              op_legal;

   assign op_legal = (Op == OP_ADD) || (Op == OP_LW) || (Op == OP_SW) ||
                     (Op == OP_BEQ) || (Op == OP_ADDI);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= S_FETCH;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      state_d = S_FETCH;
      op_d    = op_q;
      case (state_q)
         S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            op_d = Op;
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_d = op_legal ? S_EXEC : S_HALT;
`else
            state_d = op_legal ? S_EXEC : S_FETCH;
`endif
         end
         S_EXEC: begin
            if ((op_q == OP_ADD) || (op_q == OP_ADDI))
               state_d = S_WB;
            else if ((op_q == OP_LW) || (op_q == OP_SW))
               state_d = S_MEM;
            else
               state_d = S_FETCH;
         end
         S_MEM: begin
            if (!MemReady)
               state_d = S_MEM;
            else
               state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
         end
         S_WB:     state_d = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
         S_HALT:   state_d = S_HALT;
`endif
         default:  state_d = S_FETCH;
      endcase
   end

   always_comb begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemToReg   = 1'b0;
      RegDst     = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUcontrol = ALU_ADD;
      PCSrc      = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      IllegalOp  = 1'b0;
`endif
      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = MemReady;
            PCWrite = MemReady;
         end
         S_DECODE: ALUSrcB = 2'b11;
         S_EXEC: begin
            case (op_q)
               OP_ADD: ALUSrcA = 1'b1;
               OP_ADDI, OP_LW, OP_SW: begin
                  ALUSrcA = 1'b1;
                  ALUSrcB = 2'b10;
               end
               OP_BEQ: begin
                  ALUSrcA    = 1'b1;
                  ALUcontrol = ALU_SUB;
                  PCSrc      = 1'b1;
                  PCWrite    = Zero;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            IorD     = 1'b1;
            MemRead  = (op_q == OP_LW);
            MemWrite = (op_q == OP_SW);
         end
         S_WB: begin
            RegWrite = 1'b1;
            RegDst   = (op_q == OP_ADD);
            MemToReg = (op_q == OP_LW);
         end
`ifdef CTRL_ILLEGAL_TRAP_EN
         S_HALT: begin
            ALUcontrol = '0;
            IllegalOp  = 1'b1;
         end
`endif
         default: ALUcontrol = '0;
      endcase
      // Reset is asynchronous, so outputs are gated directly rather than waiting on state.
      if (Reset) begin
         PCWrite    = 1'b0;
         IRWrite    = 1'b0;
         IorD       = 1'b0;
         MemRead    = 1'b0;
         MemWrite   = 1'b0;
         MemToReg   = 1'b0;
         RegDst     = 1'b0;
         RegWrite   = 1'b0;
         ALUSrcA    = 1'b0;
         ALUSrcB    = 2'b00;
         ALUcontrol = '0;
         PCSrc      = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
         IllegalOp  = 1'b0;
`endif
      end
   end

   assign State = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit; honours CTRL_ILLEGAL_TRAP_EN.
module tb_multicycle_control_unit;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [5:0] Op;
   logic       Zero;
   logic       MemReady;
   logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, MemToReg;
   logic       RegDst, RegWrite, ALUSrcA, PCSrc;
   logic [1:0] ALUSrcB;
   logic [3:0] ALUcontrol;
   logic [2:0] State;
`ifdef CTRL_ILLEGAL_TRAP_EN
   logic       IllegalOp;
`endif
   logic [15:0] ctl;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // {PCWrite,IRWrite,IorD,MemRead,MemWrite,MemToReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUcontrol,PCSrc}
   localparam logic [15:0] V_RST        = 16'h0000;
   localparam logic [15:0] V_FETCH_RDY  = {1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,4'b0101,1'b0};
   localparam logic [15:0] V_FETCH_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,4'b0101,1'b0};
   localparam logic [15:0] V_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,4'b0101,1'b0};
   localparam logic [15:0] V_EXEC_ADD   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,4'b0101,1'b0};
   localparam logic [15:0] V_EXEC_IMM   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,4'b0101,1'b0};
   localparam logic [15:0] V_EXEC_BEQ_T = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,4'b0110,1'b1};
   localparam logic [15:0] V_EXEC_BEQ_N = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,4'b0110,1'b1};
   localparam logic [15:0] V_MEM_LW     = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,4'b0101,1'b0};
   localparam logic [15:0] V_MEM_SW     = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,4'b0101,1'b0};
   localparam logic [15:0] V_WB_ADD     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,4'b0101,1'b0};
   localparam logic [15:0] V_WB_ADDI    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,4'b0101,1'b0};
   localparam logic [15:0] V_WB_LW      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,4'b0101,1'b0};

   localparam logic [5:0] OP_ADD  = 6'b000001;
   localparam logic [5:0] OP_LW   = 6'b000010;
   localparam logic [5:0] OP_SW   = 6'b000101;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   multicycle_control_unit #(
      .OP_W   (6),
      .ALUC_W (4)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Op         (Op),
      .Zero       (Zero),
      .MemReady   (MemReady),
      .PCWrite    (PCWrite),
      .IRWrite    (IRWrite),
      .IorD       (IorD),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .MemToReg   (MemToReg),
      .RegDst     (RegDst),
      .RegWrite   (RegWrite),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ALUcontrol (ALUcontrol),
      .PCSrc      (PCSrc),
      .State      (State)
`ifdef CTRL_ILLEGAL_TRAP_EN
      ,
      .IllegalOp  (IllegalOp)
`endif
   );

   assign ctl = {PCWrite, IRWrite, IorD, MemRead, MemWrite, MemToReg, RegDst,
                 RegWrite, ALUSrcA, ALUSrcB, ALUcontrol, PCSrc};

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drives one cycle's inputs after the falling edge and checks the settled outputs.
   task automatic step(input string tag, input logic rst, input logic [5:0] op,
                       input logic z, input logic mr,
                       input logic [2:0] exp_state, input logic [15:0] exp_ctl);
      @(negedge Clk);
      Reset    = rst;
      Op       = op;
      Zero     = z;
      MemReady = mr;
      #1;
      check({tag, "/state"}, 16'(State), 16'(exp_state));
      check({tag, "/ctl"}, ctl, exp_ctl);
      check({tag, "/excl"}, 16'(MemRead & MemWrite), 16'h0000);
   endtask

   initial begin
      Reset = 1'b1; Op = '0; Zero = 1'b0; MemReady = 1'b1;

      step("por0", 1'b1, OP_BAD, 1'b1, 1'b1, 3'd0, V_RST);
      step("por1", 1'b1, OP_BAD, 1'b1, 1'b1, 3'd0, V_RST);
`ifdef CTRL_ILLEGAL_TRAP_EN
      check("por/illegal", 16'(IllegalOp), 16'h0000);
`endif

      // ADD, with junk on Op outside DECODE
      step("add_f", 1'b0, OP_BAD,  1'b0, 1'b1, 3'd0, V_FETCH_RDY);
      step("add_d", 1'b0, OP_ADD,  1'b0, 1'b1, 3'd1, V_DECODE);
      step("add_e", 1'b0, OP_BEQ,  1'b1, 1'b1, 3'd2, V_EXEC_ADD);
      step("add_w", 1'b0, OP_LW,   1'b0, 1'b1, 3'd4, V_WB_ADD);

      // Reset held three cycles in the middle of an ADD's EXEC
      step("rst_f", 1'b0, OP_BAD,  1'b0, 1'b1, 3'd0, V_FETCH_RDY);
      step("rst_d", 1'b0, OP_ADD,  1'b0, 1'b1, 3'd1, V_DECODE);
      step("rst_e", 1'b0, OP_SW,   1'b0, 1'b1, 3'd2, V_EXEC_ADD);
      for (int i = 0; i < 3; i++)
         step("rst_hold", 1'b1, OP_ADD, 1'b1, 1'b1, 3'd0, V_RST);
      step("rst_rel", 1'b0, OP_BAD, 1'b0, 1'b1, 3'd0, V_FETCH_RDY);

      // LW with two wait cycles in MEM
      step("lw_d",  1'b0, OP_LW,   1'b0, 1'b1, 3'd1, V_DECODE);
      step("lw_e",  1'b0, OP_ADD,  1'b0, 1'b1, 3'd2, V_EXEC_IMM);
      step("lw_m0", 1'b0, OP_ADD,  1'b0, 1'b0, 3'd3, V_MEM_LW);
      step("lw_m1", 1'b0, OP_ADD,  1'b0, 1'b0, 3'd3, V_MEM_LW);
      step("lw_m2", 1'b0, OP_ADD,  1'b0, 1'b1, 3'd3, V_MEM_LW);
      step("lw_w",  1'b0, OP_ADD,  1'b0, 1'b1, 3'd4, V_WB_LW);

      // SW preceded by a FETCH wait
      step("sw_fw", 1'b0, OP_BAD,  1'b0, 1'b0, 3'd0, V_FETCH_WAIT);
      step("sw_f",  1'b0, OP_BAD,  1'b0, 1'b1, 3'd0, V_FETCH_RDY);
      step("sw_d",  1'b0, OP_SW,   1'b0, 1'b1, 3'd1, V_DECODE);
      step("sw_e",  1'b0, OP_LW,   1'b0, 1'b1, 3'd2, V_EXEC_IMM);
      step("sw_m",  1'b0, OP_LW,   1'b0, 1'b1, 3'd3, V_MEM_SW);

      // BEQ taken then not taken
      step("beq1_f", 1'b0, OP_BAD, 1'b0, 1'b1, 3'd0, V_FETCH_RDY);
      step("beq1_d", 1'b0, OP_BEQ, 1'b0, 1'b1, 3'd1, V_DECODE);
      step("beq1_e", 1'b0, OP_ADD, 1'b1, 1'b1, 3'd2, V_EXEC_BEQ_T);
      step("beq0_f", 1'b0, OP_BAD, 1'b1, 1'b1, 3'd0, V_FETCH_RDY);
      step("beq0_d", 1'b0, OP_BEQ, 1'b1, 1'b1, 3'd1, V_DECODE);
      step("beq0_e", 1'b0, OP_ADD, 1'b0, 1'b1, 3'd2, V_EXEC_BEQ_N);

      // ADDI
      step("addi_f", 1'b0, OP_BAD,  1'b0, 1'b1, 3'd0, V_FETCH_RDY);
      step("addi_d", 1'b0, OP_ADDI, 1'b0, 1'b1, 3'd1, V_DECODE);
      step("addi_e", 1'b0, OP_LW,   1'b0, 1'b1, 3'd2, V_EXEC_IMM);
      step("addi_w", 1'b0, OP_LW,   1'b0, 1'b1, 3'd4, V_WB_ADDI);

      // Undefined opcode
      step("ill_f", 1'b0, OP_ADD, 1'b0, 1'b1, 3'd0, V_FETCH_RDY);
      step("ill_d", 1'b0, OP_BAD, 1'b0, 1'b1, 3'd1, V_DECODE);
`ifdef CTRL_ILLEGAL_TRAP_EN
      for (int i = 0; i < 10; i++) begin
         step("halt", 1'b0, OP_ADD, 1'b1, 1'b1, 3'd5, V_RST);
         check("halt/illegal", 16'(IllegalOp), 16'h0001);
      end
      step("halt_rst", 1'b1, OP_ADD, 1'b0, 1'b1, 3'd0, V_RST);
      check("halt_rst/illegal", 16'(IllegalOp), 16'h0000);
      step("halt_rel", 1'b0, OP_ADD, 1'b0, 1'b1, 3'd0, V_FETCH_RDY);
      check("halt_rel/illegal", 16'(IllegalOp), 16'h0000);
`else
      step("ill_back", 1'b0, OP_ADD, 1'b0, 1'b1, 3'd0, V_FETCH_RDY);
      step("ill_d2",   1'b0, OP_BAD, 1'b0, 1'b1, 3'd1, V_DECODE);
      step("ill_back2", 1'b0, OP_ADD, 1'b0, 1'b0, 3'd0, V_FETCH_WAIT);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle registered decoder in the datapath.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and generates per-state datapath controls for a shared-memory, shared-ALU datapath.
- Adds immediate and branch instructions and a memory wait handshake.
- Opcode and ALU-control widths and encodings are parametrised.

Parameters:
- OP_W, 6, opcode width.
- ALUC_W, 4, ALU control width.
- OP_ADD, 6'b000001, register add.
- OP_LW, 6'b000010, load word.
- OP_SW, 6'b000101, store word.
- OP_BEQ, 6'b000100, branch if equal.
- OP_ADDI, 6'b001000, add immediate.
- ALU_ADD, 4'b0101, ALU add code.
- ALU_SUB, 4'b0110, ALU subtract code.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Op  in  OP_W  opcode from instruction register.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory access completes this cycle.
- PCWrite  out  1  PC load enable.
- IRWrite  out  1  instruction register load.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- MemToReg  out  1  writeback select: 1 = memory data.
- RegDst  out  1  destination select: 1 = rd, 0 = rt.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2.
- ALUcontrol  out  ALUC_W  ALU operation.
- PCSrc  out  1  PC source: 0 = ALU result, 1 = ALUOut (branch target).
- State  out  3  current state, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 are unused.
- Registered elements: the state register and OpReg (OP_W bits).
- Outputs: combinational from state, OpReg, Zero and MemReady.
- Any output not listed for a state is 0; ALUcontrol defaults to ALU_ADD.
- Reset (async, takes effect immediately):
  - state=FETCH, OpReg=0.
  - While Reset is high, every output is forced to 0 and State=0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01.
  - If MemReady=1: IRWrite=1, PCWrite=1, PCSrc=0, next state DECODE.
  - Else: hold in FETCH with no writes.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALU_ADD (precomputes branch target).
  - OpReg<=Op.
  - Next EXEC if Op is one of the five defined opcodes; otherwise next FETCH, with no register or memory write (illegal op acts as NOP).
- EXEC:
  - ADD: ALUSrcA=1, ALUSrcB=00, ALU_ADD; next WB.
  - ADDI: ALUSrcA=1, ALUSrcB=10, ALU_ADD; next WB.
  - LW/SW: ALUSrcA=1, ALUSrcB=10, ALU_ADD; next MEM.
  - BEQ: ALUSrcA=1, ALUSrcB=00, ALU_SUB, PCSrc=1, PCWrite=Zero; next FETCH.
- MEM:
  - IorD=1. LW: MemRead=1. SW: MemWrite=1.
  - MemWrite stays asserted every waiting cycle until MemReady.
  - If MemReady=0, hold in MEM.
  - On MemReady=1: LW goes to WB, SW goes to FETCH.
- WB:
  - RegWrite=1, exactly one cycle.
  - ADD: RegDst=1, MemToReg=0.
  - ADDI: RegDst=0, MemToReg=0.
  - LW: RegDst=0, MemToReg=1.
  - Next FETCH.
- Cycle counts with MemReady tied high: ADD 4, ADDI 4, LW 5, SW 4, BEQ 3.
- Each MemReady-low cycle in FETCH or MEM adds one cycle.
- Op changes outside DECODE are ignored; OpReg is the only opcode used after DECODE.
- Unused state codes 5-7 (unreachable): all outputs 0, next state FETCH.
- Reset mid-instruction aborts it immediately. No partial write is issued after Reset rises.
- After Reset falls, the first active edge evaluates FETCH.
- Exactly one of MemRead/MemWrite may be high in any cycle; never both.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Adds a HALT state (code 5) and output port IllegalOp (1 bit).
  - An undefined opcode in DECODE moves to HALT.
  - HALT asserts IllegalOp=1 with all other outputs 0 and State=5.
  - HALT is left only by Reset; IllegalOp resets to 0.
- Not defined:
  - No HALT state and no IllegalOp port.
  - Undefined opcodes return to FETCH as a NOP.

Test Plan:
- Reset held 3 cycles mid-EXEC of ADD, MemReady=1 -> all outputs 0 and State=0 during reset; after release, FETCH shows MemRead=1, IorD=0, ALUSrcB=01.
- Op=6'b000001, MemReady=1 -> States 0,1,2,4,0. WB cycle: RegWrite=1, RegDst=1, MemToReg=0. EXEC cycle: ALUcontrol=4'b0101. 4 cycles total.
- Op=6'b000010, MemReady low 2 cycles in MEM -> MEM held 3 cycles with MemRead=1, IorD=1; then WB with RegWrite=1, MemToReg=1, RegDst=0. 7 cycles total.
- Op=6'b000101, MemReady=1 -> MEM cycle has MemWrite=1, MemRead=0. No RegWrite in any cycle. Back to FETCH after 4 cycles.
- Op=6'b000100: Zero=1 -> EXEC has PCWrite=1, PCSrc=1, ALUcontrol=4'b0110. Zero=0 -> PCWrite=0. 3 cycles either way.
- Op=6'b111111 -> without the macro: States 0,1,0 with no writes. With CTRL_ILLEGAL_TRAP_EN: State=5, IllegalOp=1, held 10 cycles until Reset.
